// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter
//   Shares one fixed-latency pipelined FP32 multiplier among NUM_REQ requesters.
//   Operand pairs are granted round-robin and registered into the multiplier.
//   A {valid, id} shadow pipeline follows each operation, so every result is
//   routed back to the requester that issued it.
//   Each requester may have at most MAX_OUT operations in flight.
//   A drain/halt sequence empties the pipe before reconfiguration.
//
// Ports
//   clock, resetn        clock, asynchronous active-low reset
//   req_valid/a/b        per-requester operand pairs (32 bits each, packed by index)
//   req_ready            one-hot combinational grant
//   mul_issue/a/b        registered operands to the multiplier
//   mul_result           multiplier output, MUL_LATENCY cycles after mul_issue
//   rsp_valid/data       one-hot registered result, single cycle, no backpressure
//   drain_req            level request to stop accepting and flush
//   drain_done           high while halted
//   busy                 high whenever not idle
//
// state  | meaning
// IDLE   | nothing in flight, accepting requests
// RUN    | operations in flight, accepting requests
// DRAIN  | no new grants, waiting for in-flight results to return
// HALTED | pipe empty, drain_done high until drain_req drops
module fp_mul_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 4,
  parameter int MAX_OUT     = 3
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  mul_issue,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  input  logic [31:0]           mul_result,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_data,
  input  logic                  drain_req,
  output logic                  drain_done,
  output logic                  busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int IFW = $clog2(NUM_REQ * MAX_OUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   gnt_id;
  logic [IDW-1:0]   issue_id;
  logic             hs;
  logic             accepting;
  logic [NUM_REQ-1:0] eligible;
  logic [2:0]       cnt [NUM_REQ];
  logic [IFW-1:0]   inflight;
  logic [IFW-1:0]   rsp_cnt;
  logic [IFW-1:0]   pending;
  logic [MUL_LATENCY-1:0] tag_v;
  logic [IDW-1:0]   tag_id [MUL_LATENCY];

  // drain_req blocks grants in the very cycle it rises, even from IDLE/RUN.
  assign accepting = ((state == IDLE) || (state == RUN)) && !drain_req;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = accepting && req_valid[i] && (cnt[i] < 3'(MAX_OUT));
  end

  always_comb begin
    req_ready = '0;
    gnt_id    = '0;
    hs        = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!hs && eligible[(int'(rr_ptr) + k) % NUM_REQ]) begin
        hs     = 1'b1;
        gnt_id = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
    if (hs) req_ready[gnt_id] = 1'b1;
  end

  // pending excludes results being delivered this cycle, so the FSM can
  // leave RUN/DRAIN the cycle after the last response instead of one later.
  always_comb begin
    inflight = '0;
    rsp_cnt  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      inflight = inflight + IFW'(cnt[i]);
      rsp_cnt  = rsp_cnt + IFW'(rsp_valid[i]);
    end
    pending = inflight - rsp_cnt;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mul_issue <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      issue_id  <= '0;
      rr_ptr    <= '0;
      tag_v     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      for (int k = 0; k < MUL_LATENCY; k++) tag_id[k] <= '0;
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else begin
      mul_issue <= hs;
      if (hs) begin
        mul_a    <= req_a[32*gnt_id +: 32];
        mul_b    <= req_b[32*gnt_id +: 32];
        issue_id <= gnt_id;
        rr_ptr   <= (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end

      tag_v[0]  <= mul_issue;
      tag_id[0] <= issue_id;
      for (int k = 1; k < MUL_LATENCY; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end

      rsp_valid <= '0;
      if (tag_v[MUL_LATENCY-1]) begin
        rsp_valid[tag_id[MUL_LATENCY-1]] <= 1'b1;
        rsp_data                         <= mul_result;
      end

      for (int i = 0; i < NUM_REQ; i++) begin
        if ((hs && gnt_id == IDW'(i)) && !rsp_valid[i])
          cnt[i] <= cnt[i] + 3'd1;
        else if (rsp_valid[i] && !(hs && gnt_id == IDW'(i)))
          cnt[i] <= cnt[i] - 3'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = (state != IDLE);
    drain_done = (state == HALTED);
    case (state)
      IDLE: begin
        if (drain_req) state_nxt = DRAIN;
        else if (hs)   state_nxt = RUN;
      end
      RUN: begin
        if (drain_req)                  state_nxt = DRAIN;
        else if (pending == '0 && !hs)  state_nxt = IDLE;
      end
      DRAIN: begin
        if (pending == '0) state_nxt = HALTED;
      end
      HALTED: begin
        if (!drain_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
module tb_fp_mul_arbiter;
  localparam int NUM_REQ = 4;
  localparam int MUL_LATENCY = 4;
  localparam int MAX_OUT = 3;

  logic                  clock;
  logic                  resetn;
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  mul_issue;
  logic [31:0]           mul_a;
  logic [31:0]           mul_b;
  logic [31:0]           mul_result;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [31:0]           rsp_data;
  logic                  drain_req;
  logic                  drain_done;
  logic                  busy;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  fp_mul_arbiter #(.NUM_REQ(NUM_REQ), .MUL_LATENCY(MUL_LATENCY), .MAX_OUT(MAX_OUT)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_issue(mul_issue), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .drain_req(drain_req), .drain_done(drain_done), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // Truncating FP32 multiply for normal operands; stands in for the real unit.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [7:0]  e;
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = a[30:23] + b[30:23] - 8'd127;
    if (p[47]) return {a[31] ^ b[31], e + 8'd1, p[46:24]};
    else       return {a[31] ^ b[31], e, p[45:23]};
  endfunction

  logic [31:0] mpipe [MUL_LATENCY];
  always @(posedge clock) begin
    mpipe[0] <= fmul(mul_a, mul_b);
    for (int k = 1; k < MUL_LATENCY; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_result = mpipe[MUL_LATENCY-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Response scoreboard: every handshake must come back MUL_LATENCY+2 cycles later.
  always @(negedge clock) begin
    if (!resetn) begin
      sb.delete();
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_t e;
          e.id   = i;
          e.data = fmul(req_a[32*i +: 32], req_b[32*i +: 32]);
          e.due  = cyc + MUL_LATENCY + 2;
          sb.push_back(e);
        end
      end
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          check("rsp_spurious", 32'(rsp_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_id", 32'(rsp_valid), 32'(1) << e.id);
          check("rsp_data", rsp_data, e.data);
          check("rsp_latency", 32'(cyc), 32'(e.due));
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        check("rsp_missing", 32'(cyc), 32'(sb[0].due));
        void'(sb.pop_front());
      end
    end
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic sample;
    @(negedge clock);
  endtask

  task automatic wait_empty;
    for (int k = 0; k < 30; k++) begin
      step;
      sample;
      if (sb.size() == 0) break;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  localparam logic [31:0] F1_0 = 32'h3F800000;
  localparam logic [31:0] F1_5 = 32'h3FC00000;
  localparam logic [31:0] F2_0 = 32'h40000000;
  localparam logic [31:0] F3_0 = 32'h40400000;
  localparam logic [31:0] F4_0 = 32'h40800000;

  logic [14:0] lim_pat;

  initial begin
    resetn    = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    drain_req = 1'b0;
    repeat (2) @(posedge clock);
    sample;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_issue", 32'(mul_issue), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy_done", {30'd0, busy, drain_done}, 32'd0);
    step;
    resetn = 1'b1;
    sample;

    // single request: 2.0 * 3.0
    step;
    req_a[31:0] = F2_0;
    req_b[31:0] = F3_0;
    req_valid   = 4'b0001;
    sample;
    check("single_ready", 32'(req_ready), 32'h1);
    step;
    req_valid = '0;
    sample;
    check("single_issue", 32'(mul_issue), 32'd1);
    check("single_mul_a", mul_a, F2_0);
    check("single_mul_b", mul_b, F3_0);
    check("single_busy", 32'(busy), 32'd1);
    repeat (4) begin step; sample; end
    step; sample;
    check("single_rsp_valid", 32'(rsp_valid), 32'h1);
    check("single_rsp_data", rsp_data, 32'h40C00000);
    step; sample;
    check("single_busy_idle", 32'(busy), 32'd0);
    check("single_rsp_hold", rsp_data, 32'h40C00000);
    check("single_rsp_low", 32'(rsp_valid), 32'd0);

    // round robin, pointer starts at 1
    req_a = {F4_0, F3_0, F2_0, F1_0};
    req_b = {F1_5, F1_5, F1_5, F1_5};
    for (int k = 0; k < 8; k++) begin
      step;
      req_valid = '1;
      sample;
      check($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(1) << ((k + 1) % NUM_REQ));
    end
    step;
    req_valid = '0;
    wait_empty;

    // outstanding limit on requester 2
    lim_pat = 15'b100_0011_1000_0111;  // bit k = expected req_ready[2] at cycle k
    for (int k = 0; k < 15; k++) begin
      step;
      req_valid = 4'b0100;
      sample;
      check($sformatf("limit_ready%0d", k), 32'(req_ready), lim_pat[k] ? 32'h4 : 32'h0);
    end
    step;
    req_valid = '0;
    wait_empty;

    // wrap: pointer at 3, requesters 1 and 3 valid
    step;
    req_valid = 4'b1010;
    sample;
    check("wrap_first", 32'(req_ready), 32'h8);
    step;
    sample;
    check("wrap_second", 32'(req_ready), 32'h2);
    step;
    req_valid = '0;
    wait_empty;

    // drain with five operations in flight (pointer at 2)
    for (int k = 0; k < 5; k++) begin
      step;
      req_valid = '1;
      sample;
    end
    step;
    drain_req = 1'b1;
    sample;
    check("drain_ready_now", 32'(req_ready), 32'd0);
    for (int k = 6; k <= 10; k++) begin
      step; sample;
      check($sformatf("drain_ready%0d", k), 32'(req_ready), 32'd0);
      check($sformatf("drain_done%0d", k), 32'(drain_done), 32'd0);
    end
    step; sample;
    check("drain_done_set", 32'(drain_done), 32'd1);
    check("drain_busy", 32'(busy), 32'd1);
    check("drain_halt_ready", 32'(req_ready), 32'd0);
    step;
    drain_req = 1'b0;
    req_valid = '0;
    sample;
    check("drain_done_hold", 32'(drain_done), 32'd1);
    step; sample;
    check("drain_done_clr", 32'(drain_done), 32'd0);
    check("drain_busy_clr", 32'(busy), 32'd0);
    check("drain_sb_empty", 32'(sb.size()), 32'd0);

    // reset with four operations in flight (pointer at 3)
    for (int k = 0; k < 4; k++) begin
      step;
      req_valid = '1;
      sample;
      if (k == 0) check("mid_first", 32'(req_ready), 32'h8);
    end
    step;
    req_valid = '0;
    resetn    = 1'b0;
    sample;
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_issue", 32'(mul_issue), 32'd0);
    check("mid_rst_mul_a", mul_a, 32'd0);
    check("mid_rst_mul_b", mul_b, 32'd0);
    check("mid_rst_rsp", 32'(rsp_valid), 32'd0);
    check("mid_rst_rsp_data", rsp_data, 32'd0);
    check("mid_rst_flags", {30'd0, busy, drain_done}, 32'd0);
    step; sample;
    step;
    resetn = 1'b1;
    sample;
    for (int k = 0; k < 10; k++) begin
      step; sample;
      check($sformatf("post_rst_rsp%0d", k), 32'(rsp_valid), 32'd0);
    end
    step;
    req_valid = '1;
    sample;
    check("post_rst_ptr", 32'(req_ready), 32'h1);
    step;
    req_valid = '0;
    wait_empty;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
